// File: rtl/mac_driver.sv
// mac_driver -- queues signed 8-bit operand pairs and issues them one at a
// time to an external multiply-accumulate unit. It waits a bounded number of
// cycles for completion, returns each accumulator value through a result
// handshake, and clears the accumulator after the final pair of a dot
// product or after a completion timeout.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// The producer holds valid and its payload stable until that edge and never
// waits for ready before asserting valid. ready may change at any time. This
// applies to in_valid/in_ready and to res_valid/res_ready. mac_valid is a
// one-cycle issue strobe with no back-pressure. mac_clr is a one-cycle clear
// strobe.
//
// Ports
//   clk, reset             clock; asynchronous active-low reset
//   in_valid/in_ready      operand push (in_a, in_b signed; in_last ends a dot product)
//   mac_valid, mac_a/b     issue strobe and operands (operands hold between issues)
//   mac_done, mac_y        completion strobe and accumulator value from the MAC
//   mac_clr                accumulator clear strobe
//   res_valid/res_ready    result handshake carrying res_y, res_last
//   err                    sticky completion-timeout flag
//   dbg_state, dbg_count   FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 CLEAR) and FIFO fill
module mac_driver #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_a,
  input  logic [7:0]             in_b,
  input  logic                   in_last,
  output logic                   mac_valid,
  output logic [7:0]             mac_a,
  output logic [7:0]             mac_b,
  input  logic                   mac_done,
  input  logic [31:0]            mac_y,
  output logic                   mac_clr,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [31:0]            res_y,
  output logic                   res_last,
  output logic                   err,
  output logic [1:0]             dbg_state,
  output logic [$clog2(DEPTH):0] dbg_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);
  localparam int TL = TIMEOUT - 1;
  localparam logic [PW:0]   FULL    = DEPTH[PW:0];
  localparam logic [PW:0]   CNT_ONE = 1;
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0] TO_LAST = TL[CW-1:0];
  localparam logic [CW-1:0] TO_ONE  = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  // Operand FIFO: entry = {a, b, last}
  logic [16:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          push;
  logic          pop;
  logic [16:0]   head;

  // FSM and registered outputs, with their next values
  state_t        state, state_n;
  logic          mac_valid_n, mac_clr_n, res_valid_n, res_last_n, err_n;
  logic [7:0]    mac_a_n, mac_b_n;
  logic [31:0]   res_y_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          last_q, last_n;

  assign in_ready  = (count != FULL);
  assign push      = in_valid && in_ready;
  assign head      = mem[rd_ptr];
  assign dbg_state = state;
  assign dbg_count = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_a, in_b, in_last};
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    pop         = 1'b0;
    state_n     = state;
    mac_valid_n = 1'b0;
    mac_a_n     = mac_a;
    mac_b_n     = mac_b;
    mac_clr_n   = 1'b0;
    // A pending result drops only after it has been accepted.
    res_valid_n = res_valid && !res_ready;
    res_y_n     = res_y;
    res_last_n  = res_last;
    err_n       = err;
    cnt_n       = cnt;
    last_n      = last_q;
    case (state)
      IDLE: begin
        // Accepting the final result of a dot product takes priority over
        // issuing, so the accumulator is cleared before the next pair.
        if (res_valid && res_ready && res_last) begin
          state_n   = CLEAR;
          mac_clr_n = 1'b1;
        end else if (count != '0 && !res_valid) begin
          pop         = 1'b1;
          state_n     = ISSUE;
          mac_valid_n = 1'b1;
          mac_a_n     = head[16:9];
          mac_b_n     = head[8:1];
          last_n      = head[0];
        end
      end
      ISSUE: begin
        state_n = WAIT;
        cnt_n   = '0;
      end
      WAIT: begin
        if (mac_done) begin
          state_n     = IDLE;
          res_valid_n = 1'b1;
          res_y_n     = mac_y;
          res_last_n  = last_q;
        end else if (cnt == TO_LAST) begin
          // The pair is abandoned; clear the accumulator so the next pair
          // starts a fresh dot product.
          state_n   = CLEAR;
          err_n     = 1'b1;
          mac_clr_n = 1'b1;
        end else begin
          cnt_n = cnt + TO_ONE;
        end
      end
      CLEAR: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mac_valid <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      mac_clr   <= 1'b0;
      res_valid <= 1'b0;
      res_y     <= '0;
      res_last  <= 1'b0;
      err       <= 1'b0;
      cnt       <= '0;
      last_q    <= 1'b0;
    end else begin
      state     <= state_n;
      mac_valid <= mac_valid_n;
      mac_a     <= mac_a_n;
      mac_b     <= mac_b_n;
      mac_clr   <= mac_clr_n;
      res_valid <= res_valid_n;
      res_y     <= res_y_n;
      res_last  <= res_last_n;
      err       <= err_n;
      cnt       <= cnt_n;
      last_q    <= last_n;
    end
  end

endmodule

// File: tb/tb_mac_driver.sv
// Bench for mac_driver: a behavioural MAC unit, a result scoreboard fed by a
// dot-product reference, directed sequences and randomized dot products.
module tb_mac_driver;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        in_last = 1'b0;
  logic        mac_valid;
  logic [7:0]  mac_a;
  logic [7:0]  mac_b;
  logic        mac_done = 1'b0;
  logic [31:0] mac_y = '0;
  logic        mac_clr;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_y;
  logic        res_last;
  logic        err;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_count;

  mac_driver #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mac_valid(mac_valid), .mac_a(mac_a), .mac_b(mac_b),
    .mac_done(mac_done), .mac_y(mac_y), .mac_clr(mac_clr),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_y(res_y), .res_last(res_last),
    .err(err), .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // ---------------- behavioural MAC unit ----------------
  // mdl_mode: 0 = done lat cycles after the issue strobe, 1 = never done,
  // 2 = like 0 but done is also held high outside the wait window, with a
  // bogus value during the issue cycle.
  int mdl_mode = 0;
  int lat = 2;
  int acc = 0;
  int age = 0;
  bit pend = 0;

  always @(posedge clk) begin
    if (!reset) begin
      acc = 0;
      pend = 0;
      age = 0;
      #1;
      mac_done = 1'b0;
      mac_y = '0;
    end else begin
      if (mac_clr) acc = 0;
      if (mac_valid) begin
        acc = acc + int'($signed(mac_a)) * int'($signed(mac_b));
        pend = (mdl_mode != 1);
        age = 0;
      end else if (pend) begin
        age++;
        if (age >= lat) pend = 0;
      end
      #1;
      if (pend && age == lat - 1) begin
        mac_done = 1'b1;
        mac_y = acc;
      end else if (pend) begin
        mac_done = 1'b0;
      end else if (mdl_mode == 2) begin
        mac_done = 1'b1;
        if (mac_valid) mac_y = 32'hDEAD_BEEF;
      end else begin
        mac_done = 1'b0;
      end
    end
  end

  // ---------------- result ready driver ----------------
  bit rand_rr = 0;
  bit rr_fixed = 1;
  always @(posedge clk) begin
    #1;
    res_ready = rand_rr ? ($urandom_range(0, 1) == 1) : rr_fixed;
  end

  // ---------------- monitor / scoreboard ----------------
  int stab_viol = 0;
  int mv_viol = 0;
  int mvrv_viol = 0;
  int clr_cnt = 0;
  int mv_cnt = 0;
  int rv_cnt = 0;
  int last_mv_cyc = 0;
  bit prev_hold = 0;
  bit prev_mv = 0;
  logic [31:0] prev_y;
  logic prev_last;
  logic [32:0] e;

  always @(negedge clk) begin
    if (!reset) begin
      prev_hold = 0;
      prev_mv = 0;
    end else begin
      if (prev_hold && (!res_valid || res_y !== prev_y || res_last !== prev_last)) stab_viol++;
      if (prev_mv && mac_valid) mv_viol++;
      if (mac_valid && res_valid) mvrv_viol++;
      if (mac_clr) clr_cnt++;
      if (mac_valid) begin
        mv_cnt++;
        last_mv_cyc = cyc;
      end
      if (res_valid) rv_cnt++;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(res_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("res_y", res_y, e[31:0]);
          chk("res_last", 32'(res_last), 32'(e[32]));
        end
      end
      prev_hold = res_valid && !res_ready;
      prev_y = res_y;
      prev_last = res_last;
      prev_mv = mac_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic l);
    int g = 0;
    in_a = a;
    in_b = b;
    in_last = l;
    @(negedge clk);
    in_valid = 1'b1;
    while (!in_ready && g < 1000) begin
      g++;
      @(negedge clk);
    end
    if (!in_ready) begin
      fail("push");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int g = 0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && dbg_count == 0 && dbg_state == 2'd0 &&
             !res_valid && !mac_valid) && g < 3000) begin
      g++;
      @(negedge clk);
    end
    if (g >= 3000) fail(name);
  endtask

  task automatic wait_rv(input string name);
    int g = 0;
    @(negedge clk);
    while (!res_valid && g < 200) begin
      g++;
      @(negedge clk);
    end
    if (!res_valid) fail(name);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        last;
    logic [31:0] y;
  } vec_t;
  vec_t tbl [7];

  int run_sum;
  int g;
  int n1;
  int len;
  logic [7:0] ra, rb;

  initial begin
    tbl[0] = '{8'sd5,  8'sd3,  1'b0, 32'sd15};
    tbl[1] = '{8'sd4,  -8'sd2, 1'b0, 32'sd7};
    tbl[2] = '{-8'sd6, 8'sd1,  1'b0, 32'sd1};
    tbl[3] = '{8'sd7,  8'sd2,  1'b0, 32'sd15};
    tbl[4] = '{-8'sd3, -8'sd4, 1'b0, 32'sd27};
    tbl[5] = '{8'sd2,  8'sd6,  1'b0, 32'sd39};
    tbl[6] = '{-8'sd1, 8'sd5,  1'b1, 32'sd34};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mac_valid", 32'(mac_valid), 32'd0);
    chk("rst_mac_a", 32'(mac_a), 32'd0);
    chk("rst_mac_b", 32'(mac_b), 32'd0);
    chk("rst_mac_clr", 32'(mac_clr), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_y", res_y, 32'd0);
    chk("rst_res_last", 32'(res_last), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b1;

    // Table-driven dot product, MAC done 2 cycles after issue
    clr_cnt = 0;
    for (int i = 0; i < 7; i++) exp_q.push_back({tbl[i].last, tbl[i].y});
    push(tbl[0].a, tbl[0].b, tbl[0].last);
    @(negedge clk);
    chk("first_issue_not_early", 32'(mac_valid), 32'd0);
    chk("first_push_count", 32'(dbg_count), 32'd1);
    @(negedge clk);
    chk("first_issue", 32'(mac_valid), 32'd1);
    chk("first_issue_a", 32'(mac_a), 32'd5);
    chk("first_issue_b", 32'(mac_b), 32'd3);
    @(negedge clk);
    chk("operand_hold_valid", 32'(mac_valid), 32'd0);
    chk("operand_hold_a", 32'(mac_a), 32'd5);
    for (int i = 1; i < 7; i++) push(tbl[i].a, tbl[i].b, tbl[i].last);
    wait_drain("drain_table");
    chk("clr_pulses_table", 32'(clr_cnt), 32'd1);

    // Result back-pressure with a full operand FIFO
    rr_fixed = 0;
    for (int i = 0; i < 6; i++) exp_q.push_back({(i == 5) ? 1'b1 : 1'b0, tbl[i].y});
    for (int i = 0; i < 5; i++) push(tbl[i].a, tbl[i].b, 1'b0);
    wait_rv("wait_first_result");
    chk("bp_res_y", res_y, 32'd15);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_count", 32'(dbg_count), 32'd4);
    mv_cnt = 0;
    repeat (10) @(negedge clk);
    chk("bp_no_issue", 32'(mv_cnt), 32'd0);
    chk("bp_res_valid_held", 32'(res_valid), 32'd1);
    chk("bp_res_y_held", res_y, 32'd15);
    rr_fixed = 1;
    push(tbl[5].a, tbl[5].b, 1'b1);
    wait_drain("drain_backpressure");

    // mac_done held high through the issue cycle with a bogus value
    mdl_mode = 2;
    exp_q.push_back({1'b0, 32'sd9});
    exp_q.push_back({1'b1, -32'sd1});
    push(8'sd3, 8'sd3, 1'b0);
    push(8'sd2, -8'sd5, 1'b1);
    wait_drain("drain_done_held");
    mdl_mode = 0;

    // Simultaneous push and pop with three entries queued
    rr_fixed = 0;
    exp_q.push_back({1'b0, 32'sd2});
    exp_q.push_back({1'b0, 32'sd5});
    exp_q.push_back({1'b0, 32'sd1});
    exp_q.push_back({1'b0, 32'sd17});
    exp_q.push_back({1'b1, 32'sd10});
    push(8'sd1, 8'sd2, 1'b0);
    push(8'sd3, 8'sd1, 1'b0);
    push(-8'sd2, 8'sd2, 1'b0);
    push(8'sd4, 8'sd4, 1'b0);
    wait_rv("wait_pp_result");
    chk("pp_count_before", 32'(dbg_count), 32'd3);
    rr_fixed = 1;
    g = 0;
    while (!(res_valid && res_ready) && g < 20) begin
      g++;
      @(negedge clk);
    end
    if (!(res_valid && res_ready)) fail("wait_pp_accept");
    @(posedge clk);
    #1;
    in_a = 8'sd1;
    in_b = -8'sd7;
    in_last = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("pp_count_after", 32'(dbg_count), 32'd3);
    chk("pp_issue", 32'(mac_valid), 32'd1);
    chk("pp_issue_a", 32'(mac_a), 32'd3);
    chk("pp_issue_b", 32'(mac_b), 32'd1);
    wait_drain("drain_push_pop");

    // Completion timeout, then operation continues
    chk("err_before_timeout", 32'(err), 32'd0);
    mdl_mode = 1;
    exp_q.push_back({1'b1, 32'sd6});
    push(8'sd1, 8'sd1, 1'b0);
    push(8'sd2, 8'sd3, 1'b1);
    g = 0;
    @(negedge clk);
    while (!err && g < 100) begin
      g++;
      @(negedge clk);
    end
    if (!err) fail("wait_err");
    n1 = cyc;
    chk("timeout_latency", 32'(n1 - last_mv_cyc), 32'(TIMEOUT + 1));
    chk("timeout_clr", 32'(mac_clr), 32'd1);
    chk("timeout_state", 32'(dbg_state), 32'd3);
    chk("timeout_no_result", 32'(res_valid), 32'd0);
    mdl_mode = 0;
    wait_drain("drain_timeout");

    // Randomized dot products against the running-sum reference
    for (int batch = 0; batch < 3; batch++) begin
      lat = $urandom_range(1, 4);
      rand_rr = 1;
      for (int k = 0; k < 6; k++) begin
        len = $urandom_range(1, 5);
        run_sum = 0;
        for (int j = 0; j < len; j++) begin
          ra = 8'($urandom_range(0, 255));
          rb = 8'($urandom_range(0, 255));
          run_sum = run_sum + int'($signed(ra)) * int'($signed(rb));
          exp_q.push_back({(j == len - 1) ? 1'b1 : 1'b0, 32'(run_sum)});
          repeat ($urandom_range(0, 2)) @(posedge clk);
          push(ra, rb, (j == len - 1) ? 1'b1 : 1'b0);
        end
      end
      wait_drain("drain_random");
      rand_rr = 0;
    end
    lat = 2;
    chk("err_sticky", 32'(err), 32'd1);

    // Reset while waiting with three pairs queued
    mdl_mode = 1;
    for (int i = 0; i < 4; i++) push(tbl[i].a, tbl[i].b, 1'b0);
    g = 0;
    @(negedge clk);
    while (!(dbg_state == 2'd2 && dbg_count == 3'd3) && g < 50) begin
      g++;
      @(negedge clk);
    end
    if (!(dbg_state == 2'd2 && dbg_count == 3'd3)) fail("wait_mid_wait");
    #2;
    reset = 1'b0;
    #1;
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    chk("ar_count", 32'(dbg_count), 32'd0);
    chk("ar_state", 32'(dbg_state), 32'd0);
    chk("ar_mac_valid", 32'(mac_valid), 32'd0);
    chk("ar_mac_a", 32'(mac_a), 32'd0);
    chk("ar_mac_b", 32'(mac_b), 32'd0);
    chk("ar_mac_clr", 32'(mac_clr), 32'd0);
    chk("ar_res_valid", 32'(res_valid), 32'd0);
    chk("ar_res_y", res_y, 32'd0);
    chk("ar_res_last", 32'(res_last), 32'd0);
    chk("ar_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mdl_mode = 0;
    rv_cnt = 0;
    mv_cnt = 0;
    repeat (20) @(negedge clk);
    chk("ar_no_result", 32'(rv_cnt), 32'd0);
    chk("ar_no_issue", 32'(mv_cnt), 32'd0);
    chk("ar_in_ready_after", 32'(in_ready), 32'd1);

    // Whole-run protocol observations
    chk("res_stable_while_stalled", 32'(stab_viol), 32'd0);
    chk("mac_valid_single_cycle", 32'(mv_viol), 32'd0);
    chk("no_issue_with_result_pending", 32'(mvrv_viol), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_driver.md
MAC_DRIVER -- requirements
Module: mac_driver

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning operand FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 16, meaning max cycles spent in WAIT for mac_done (>=2).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1  operand-push handshake.
REQ-006 SHALL have ports in_a input 8, in_b input 8, in_last input 1  signed operands; in_last marks final pair of a dot product.
REQ-007 SHALL have ports mac_valid output 1, mac_a output 8, mac_b output 8  issue to MAC.
REQ-008 SHALL have ports mac_done input 1, mac_y input 32 (signed)  MAC completion and accumulator.
REQ-009 SHALL have port mac_clr  output 1  one-cycle active-high accumulator clear to MAC.
REQ-010 SHALL have ports res_valid output 1, res_ready input 1, res_y output 32, res_last output 1  result handshake.
REQ-011 SHALL have port err  output 1  sticky timeout flag.

Function
REQ-012 SHALL push {in_a,in_b,in_last} into FIFO when in_valid && in_ready; in_ready = !full (combinational from count only).
REQ-013 SHALL support simultaneous push and pop in one cycle; count unchanged; pointers wrap modulo DEPTH.
REQ-014 SHALL implement FSM IDLE, ISSUE, WAIT, CLEAR, all outputs registered.
REQ-015 IDLE -> ISSUE when FIFO non-empty && !res_valid; at that edge pop head, load mac_a/mac_b, set mac_valid=1, latch last flag.
REQ-016 ISSUE lasts exactly one cycle (mac_valid high exactly one cycle) -> WAIT; mac_done ignored in ISSUE.
REQ-017 WAIT: timeout counter starts at 0, increments each cycle; mac_done sampled only in WAIT.
REQ-018 WAIT with mac_done=1: capture mac_y into res_y, latched last into res_last, set res_valid=1 -> IDLE.
REQ-019 WAIT with counter == TIMEOUT-1 and mac_done=0: set err=1, drop pair, no result, assert mac_clr -> CLEAR.
REQ-020 res_valid/res_y/res_last SHALL hold stable until res_valid && res_ready; then res_valid=0 next cycle.
REQ-021 Result accepted with res_last=1 -> CLEAR from IDLE before next issue: mac_clr=1 for one cycle, then IDLE; no issue while in CLEAR.
REQ-022 mac_a/mac_b SHALL hold last issued values when mac_valid=0.
REQ-023 err SHALL stay 1 until reset; operation continues after timeout.
REQ-024 Arithmetic none beyond counters; mac_y passed through unmodified (no sign or width change).

Reset
REQ-025 reset=0 SHALL asynchronously force: state IDLE, FIFO empty (in_ready=1), mac_valid=0, mac_a=mac_b=0, mac_clr=0, res_valid=0, res_y=0, res_last=0, err=0, timeout counter 0.
REQ-026 Reset mid-WAIT or mid-CLEAR SHALL discard in-flight pair and queued entries; no result emitted after release.
REQ-027 First issue after reset release SHALL occur no earlier than one cycle after first push.

Verification
REQ-028 Push (5,3),(4,-2),(-6,1),(7,2),(-3,-4),(2,6),(-1,5 last), MAC model done 2 cycles after mac_valid, res_ready=1 -> res_y 15,7,1,15,27,39,34; res_last only on 34; one mac_clr pulse after 34.
REQ-029 res_ready=0 for 10 cycles after first result, push 6 pairs -> in_ready=0 after DEPTH=4 queued, res_y=15 held stable, no mac_valid until accept; sequence then completes in order.
REQ-030 Model never asserts mac_done -> err=1 exactly TIMEOUT cycles after entering WAIT, mac_clr pulse, next pair issued, no res_valid for dropped pair.
REQ-031 mac_done held high through ISSUE from prior op -> ignored; result captured only from WAIT-cycle done.
REQ-032 Assert reset=0 during WAIT with 3 queued -> all outputs reset values immediately; after release no res_valid, in_ready=1.
REQ-033 Push and pop in same cycle with FIFO at 3/4 -> count stays 3, order preserved across pointer wrap.
